// File: rtl/attempt_limiter.sv
// attempt_limiter: counts consecutive failed code submissions and locks out
// further attempts after MAX_TRIES failures. Each accepted attempt produces a
// one-cycle grant pulse, and each entry into lockout produces a one-cycle alarm
// pulse.
// Optional feature macro: ATTEMPT_LIMITER_TIMEOUT_EN
//   defined   -> lockout expires by itself after LOCK_CYCLES clock cycles
//   undefined -> lockout lasts until admin_clr or rst; remain is tied to 0
module attempt_limiter #(
  parameter int MAX_TRIES   = 3,
  parameter int LOCK_CYCLES = 1000,
  parameter int CNT_W       = $clog2(MAX_TRIES + 1),
  parameter int TMR_W       = $clog2(LOCK_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             ok,
  input  logic             admin_clr,
  output logic [CNT_W-1:0] count,
  output logic             locked,
  output logic             granted,
  output logic             alarm,
  output logic [TMR_W-1:0] remain
);

  localparam logic [0:0]       ST_OPEN   = 1'b0;
  localparam logic [0:0]       ST_LOCKED = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_TRIES);
  localparam logic [CNT_W:0]   TRIES_EXT = (CNT_W + 1)'(MAX_TRIES);

  logic [0:0]     state;
  logic           btn_q;
  logic           press;
  logic [CNT_W:0] count_inc;
  logic           fail_locks;
  logic           lock_entry;
  logic           expire;

  // The count is incremented one bit wider so that comparing it with
  // MAX_TRIES cannot wrap, even when MAX_TRIES fills CNT_W exactly.
  assign press      = btn & ~btn_q;
  assign count_inc  = {1'b0, count} + 1'b1;
  assign fail_locks = (count_inc >= TRIES_EXT);
  assign lock_entry = (state == ST_OPEN) && press && !ok && fail_locks && !admin_clr;
  assign locked     = (state == ST_LOCKED);

  // Track the previous btn level in every state. A press held across an
  // unlock therefore does not show up as a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
    end else begin
      btn_q <= btn;
    end
  end

`ifdef ATTEMPT_LIMITER_TIMEOUT_EN
  // Expiry happens on the last locked cycle, which is when remain reads 1.
  assign expire = (state == ST_LOCKED) && (remain == TMR_W'(1));

  // The lockout countdown loads on lock entry and runs down to 0. An
  // administrative clear forces it to 0 straight away.
  always_ff @(posedge clk) begin
    if (rst) begin
      remain <= '0;
    end else if (admin_clr) begin
      remain <= '0;
    end else if (lock_entry) begin
      remain <= TMR_W'(LOCK_CYCLES);
    end else if ((state == ST_LOCKED) && (remain != '0)) begin
      remain <= remain - 1'b1;
    end
  end
`else
  // Without the timer, only admin_clr or rst can end a lockout.
  assign expire = 1'b0;
  assign remain = '0;
`endif

  // Main control. Priority is admin_clr, then timer expiry, then a detected
  // press. Presses are only acted on while OPEN. The pulse outputs default
  // to 0, so each one lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_OPEN;
      count   <= '0;
      granted <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      granted <= 1'b0;
      alarm   <= 1'b0;
      if (admin_clr) begin
        state <= ST_OPEN;
        count <= '0;
      end else if (expire) begin
        state <= ST_OPEN;
        count <= '0;
      end else if ((state == ST_OPEN) && press) begin
        if (ok) begin
          granted <= 1'b1;
          count   <= '0;
        end else if (fail_locks) begin
          state <= ST_LOCKED;
          count <= CNT_MAX;
          alarm <= 1'b1;
        end else begin
          count <= count_inc[CNT_W-1:0];
        end
      end
    end
  end

endmodule

// File: doc/attempt_limiter.md
# attempt_limiter

Clocked, parametrised successor to the wrong-attempt counter in the digital lock. Counts failed code submissions, raises a lockout after `MAX_TRIES` consecutive failures, and reports a one-cycle grant or alarm pulse for each outcome. Sits between the keypad/compare logic, which supplies `btn` and `ok`, and the door/alarm outputs. Lockout expiry is either timed or administrative, selected at compile time.

## Interface
Parameters:
- `MAX_TRIES`, default 3: consecutive failures that trigger lockout; legal range ≥1.
- `LOCK_CYCLES`, default 1000: lockout duration in `clk` cycles, used only with timed expiry; legal range ≥1.
- `CNT_W`, default `$clog2(MAX_TRIES+1)`: width of `count`.
- `TMR_W`, default `$clog2(LOCK_CYCLES+1)`: width of `remain`.

Ports:
- `clk`  in  1  system clock; all logic is rising-edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn`  in  1  submit strobe, level, synchronous to `clk`. The block detects its rising edge internally.
- `ok`  in  1  compare result, sampled on the cycle the `btn` rising edge is detected. 1 = correct code.
- `admin_clr`  in  1  administrative unlock and counter clear. Single-cycle or held.
- `count`  out  CNT_W  consecutive failures so far. Saturates at `MAX_TRIES`.
- `locked`  out  1  lockout active.
- `granted`  out  1  one-cycle pulse when a correct attempt is accepted.
- `alarm`  out  1  one-cycle pulse on entry to lockout.
- `remain`  out  TMR_W  cycles of lockout left. Reads 0 when not locked.

## Operation
- Edge detect: register `btn_q` each cycle. `edge = btn & ~btn_q`.
- States: OPEN and LOCKED.
- OPEN, `edge & ok`: `granted`=1 for one cycle, `count` goes to 0.
- OPEN, `edge & ~ok`, with `count+1 < MAX_TRIES`: `count` increments.
- OPEN, `edge & ~ok`, with `count+1 == MAX_TRIES`:
  - `count` goes to `MAX_TRIES`.
  - Go to LOCKED, `locked`=1, `alarm`=1 for one cycle.
  - `remain` loads `LOCK_CYCLES` (timed mode only).
- LOCKED:
  - `btn` edges are ignored; `count` and `granted` do not change.
  - `btn_q` keeps tracking, so a press held across unlock does not produce a new edge.
- LOCKED, timed mode: `remain` decrements every cycle. On the cycle `remain==1`, the next state is OPEN with `count`=0 and `remain`=0.
- `admin_clr` in any state: go to OPEN, `count`=0, `remain`=0, no pulses.
- Priority: `rst` > `admin_clr` > timer expiry > `edge`.
  - An edge in the same cycle as `admin_clr` is dropped.
  - An edge in the same cycle as expiry is ignored, because the block is still LOCKED on that cycle.
- `MAX_TRIES`=1: the first failure locks immediately.
- No counter wraps. `count` saturates, and `remain` never decrements below 0.

## Timing
- All outputs are registered.
- Reset values: `count`=0, `locked`=0, `granted`=0, `alarm`=0, `remain`=0, `btn_q`=0, state OPEN.
- Latency: `btn` first sampled high at edge k (with `btn_q`=0) → outputs update at edge k. They are visible for cycle k+1.
- Back-to-back attempts need `btn` low for at least one sampled cycle between highs.
- Lockout length in timed mode: `locked` is high for exactly `LOCK_CYCLES` cycles. `alarm` coincides with the first of those cycles.
- `remain` reads `LOCK_CYCLES` on the first locked cycle and 1 on the last.
- `rst` during lockout returns all outputs to their reset values at the next edge.

## Configuration
- Macro: `ATTEMPT_LIMITER_TIMEOUT_EN`.
- Defined:
  - Timed expiry as described above.
  - `remain` counts down.
  - Lockout also clears on `admin_clr` or `rst`.
- Undefined:
  - No timer logic; `remain` is tied to 0 and `LOCK_CYCLES` is unused.
  - LOCKED persists until `admin_clr` or `rst`.
  - `locked` and `alarm` behaviour is otherwise identical.

## Test plan
All scenarios use `MAX_TRIES`=3 and `LOCK_CYCLES`=8.
- Reset, then two failed presses → `count`=1, then 2. `locked`=0. No pulses.
- Two failures, then a correct press (`ok`=1) → `granted` high for 1 cycle, `count`=0, `locked` stays 0.
- Three failures, timed mode:
  - On the third → `count`=3, `locked`=1, `alarm` pulse 1 cycle, `remain`=8.
  - `locked` stays high for 8 cycles, then `count`=0 and `remain`=0.
  - A press during lockout is ignored.
- `btn` held high from mid-lockout through expiry → no attempt after unlock. The next release-then-press → `count`=1.
- Lockout without the macro → `locked` stays 1 for more than 100 cycles. `admin_clr` pulse → next cycle `locked`=0, `count`=0. An edge in the same cycle as `admin_clr` is dropped.
- `rst` asserted for 1 cycle while `count`=2, and again mid-lockout → every output returns to 0 at the following edge.
